// File: rtl/fp_latency_pipe_pkg.sv
// Shared widths and lane-word type for the stallable FP latency pipeline.
// Default parameters match an 8-bit exponent / 9-bit mantissa format.
package fp_pkg;

    localparam int EXP_DEF  = 8;
    localparam int MANT_DEF = 9;

    function automatic int fp_width(input int exp_w, input int mant_w);
        return 1 + exp_w + mant_w;
    endfunction

    // An empty pipe still needs a one-bit count port.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

    typedef logic [EXP_DEF+MANT_DEF:0] fp_word_t;

endpackage

// File: rtl/fp_latency_pipe_stage.sv
// One stallable register slice: it loads whenever it is empty or the slice
// downstream is advancing, which is what lets bubbles collapse during a stall.
module fp_latency_stage
    import fp_pkg::*;
#(
    parameter int W = fp_width(EXP_DEF, MANT_DEF)
) (
    input  logic         clock,
    input  logic         clock_sreset,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         down_adv,
    output logic         v,
    output logic [W-1:0] data,
    output logic         adv
);

    logic         v_q;
    logic [W-1:0] data_q;

    assign adv  = !v_q || down_adv;
    assign v    = v_q;
    assign data = data_q;

    always_ff @(posedge clock) begin
        if (clock_sreset || flush) begin
            v_q <= 1'b0;
        end else if (adv) begin
            v_q <= in_valid;
        end
    end

    // Data is deliberately left out of reset; it is only meaningful with v.
    always_ff @(posedge clock) begin
        if (adv && in_valid) begin
            data_q <= in_data;
        end
    end

endmodule

// File: rtl/fp_latency_pipe.sv
// Multi-lane FP delay pipeline with valid/ready backpressure, bubble
// collapsing, synchronous flush and an occupancy count.
module fp_latency_pipe
    import fp_pkg::*;
#(
    parameter  int EXP     = 8,
    parameter  int MANT    = 9,
    parameter  int LANES   = 1,
    parameter  int LCYCLES = 2,
    localparam int WIDTH   = fp_width(EXP, MANT),
    localparam int CW      = cnt_width(LCYCLES)
) (
    input  logic                   clock,
    input  logic                   clock_sreset,
    input  logic                   flush,
    input  logic                   data_valid,
    output logic                   data_ready,
    input  logic [LANES*WIDTH-1:0] dataa,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [LANES*WIDTH-1:0] result,
    output logic [CW-1:0]          count
);

    localparam int VW = LANES * WIDTH;

    if (LCYCLES == 0) begin : g_passthru
        logic unused_clk_rst;
        assign unused_clk_rst = ^{clock, clock_sreset};

        assign result       = dataa;
        assign result_valid = data_valid && !flush;
        assign data_ready   = result_ready && !flush;
        assign count        = '0;
    end else begin : g_pipe
        logic [LCYCLES-1:0] v_w;
        logic [LCYCLES-1:0] adv_w;
        logic [VW-1:0]      d_w [LCYCLES];
        logic               in_xfer;
        logic               out_xfer;
        logic [CW-1:0]      count_q;
        logic [CW-1:0]      count_d;

        for (genvar gi = 0; gi < LCYCLES; gi++) begin : g_stage
            logic          in_v;
            logic [VW-1:0] in_d;
            logic          dn_adv;

            if (gi == 0) begin : g_first
                assign in_v = data_valid;
                assign in_d = dataa;
            end else begin : g_chain
                assign in_v = v_w[gi-1];
                assign in_d = d_w[gi-1];
            end

            // The last slice's advance is the combinational end of the ready chain.
            if (gi == LCYCLES - 1) begin : g_last
                assign dn_adv = result_ready;
            end else begin : g_inner
                assign dn_adv = adv_w[gi+1];
            end

            fp_latency_stage #(
                .W(VW)
            ) u_stage (
                .clock        (clock),
                .clock_sreset (clock_sreset),
                .flush        (flush),
                .in_valid     (in_v),
                .in_data      (in_d),
                .down_adv     (dn_adv),
                .v            (v_w[gi]),
                .data         (d_w[gi]),
                .adv          (adv_w[gi])
            );
        end

        assign data_ready   = adv_w[0] && !flush;
        assign result_valid = v_w[LCYCLES-1];
        assign result       = d_w[LCYCLES-1];

        assign in_xfer  = data_valid && data_ready;
        assign out_xfer = result_valid && result_ready;

        always_comb begin
            count_d = count_q;
            case ({in_xfer, out_xfer})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        always_ff @(posedge clock) begin
            if (clock_sreset || flush) begin
                count_q <= '0;
            end else begin
                count_q <= count_d;
            end
        end

        assign count = count_q;
    end

endmodule

// File: tb/tb_fp_latency_pipe.sv
// Directed bench for fp_latency_pipe: three builds (LCYCLES=3/LANES=2,
// LCYCLES=4, LCYCLES=0) driven on the falling edge and checked 1ns later.
module tb_fp_latency_pipe;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic clock_sreset;
    int   total = 0;
    int   bad   = 0;

    // Build A: LCYCLES=3, LANES=2 (36-bit vectors, 2-bit count)
    logic        fl_a, dv_a, dr_a, rv_a, rr_a;
    logic [35:0] d_a, r_a;
    logic [1:0]  cnt_a;
    // Build B: LCYCLES=4, LANES=1 (3-bit count)
    logic        fl_b, dv_b, dr_b, rv_b, rr_b;
    logic [17:0] d_b, r_b;
    logic [2:0]  cnt_b;
    // Build C: LCYCLES=0, LANES=1
    logic        fl_c, dv_c, dr_c, rv_c, rr_c;
    logic [17:0] d_c, r_c;
    logic [0:0]  cnt_c;

    fp_latency_pipe #(.EXP(8), .MANT(9), .LANES(2), .LCYCLES(3)) dut_a (
        .clock(clock), .clock_sreset(clock_sreset), .flush(fl_a),
        .data_valid(dv_a), .data_ready(dr_a), .dataa(d_a),
        .result_valid(rv_a), .result_ready(rr_a), .result(r_a), .count(cnt_a)
    );

    fp_latency_pipe #(.EXP(8), .MANT(9), .LANES(1), .LCYCLES(4)) dut_b (
        .clock(clock), .clock_sreset(clock_sreset), .flush(fl_b),
        .data_valid(dv_b), .data_ready(dr_b), .dataa(d_b),
        .result_valid(rv_b), .result_ready(rr_b), .result(r_b), .count(cnt_b)
    );

    fp_latency_pipe #(.EXP(8), .MANT(9), .LANES(1), .LCYCLES(0)) dut_c (
        .clock(clock), .clock_sreset(clock_sreset), .flush(fl_c),
        .data_valid(dv_c), .data_ready(dr_c), .dataa(d_c),
        .result_valid(rv_c), .result_ready(rr_c), .result(r_c), .count(cnt_c)
    );

    // Vector n: lane k = 0x100*n + k.
    function automatic logic [35:0] vec(input int n);
        logic [17:0] l0, l1;
        l0 = 18'(n * 256);
        l1 = 18'(n * 256 + 1);
        return {l1, l0};
    endfunction

    task automatic drive_a(input logic dv, input logic [35:0] d, input logic rr, input logic fl);
        @(negedge clock);
        dv_a = dv; d_a = d; rr_a = rr; fl_a = fl;
        #1;
    endtask

    task automatic drive_b(input logic dv, input logic [17:0] d, input logic rr);
        @(negedge clock);
        dv_b = dv; d_b = d; rr_b = rr;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        clock_sreset = 1'b1;
        @(negedge clock);
        clock_sreset = 1'b0;
        #1;
        total++; if (rv_a !== 1'b0) begin bad++; $display("FAIL reset_rv_a got=%b exp=0", rv_a); end
        total++; if (cnt_a !== 2'd0) begin bad++; $display("FAIL reset_cnt_a got=%0d exp=0", cnt_a); end
        total++; if (dr_a !== 1'b1) begin bad++; $display("FAIL reset_dr_a got=%b exp=1", dr_a); end
        total++; if (rv_b !== 1'b0) begin bad++; $display("FAIL reset_rv_b got=%b exp=0", rv_b); end
        total++; if (cnt_b !== 3'd0) begin bad++; $display("FAIL reset_cnt_b got=%0d exp=0", cnt_b); end
        $display("reset: released, pipes empty");
    endtask

    task automatic test_stream();
        int exp_cnt [13];
        logic exp_rv;
        exp_cnt = '{0, 1, 2, 3, 3, 3, 3, 3, 3, 2, 1, 0, 0};
        for (int p = 0; p < 13; p++) begin
            drive_a(p < 8, vec(p + 1), 1'b1, 1'b0);
            exp_rv = (p >= 3 && p <= 10) ? 1'b1 : 1'b0;
            total++; if (cnt_a !== 2'(exp_cnt[p])) begin bad++; $display("FAIL stream_cnt p=%0d got=%0d exp=%0d", p, cnt_a, exp_cnt[p]); end
            total++; if (dr_a !== 1'b1) begin bad++; $display("FAIL stream_ready p=%0d got=%b exp=1", p, dr_a); end
            total++; if (rv_a !== exp_rv) begin bad++; $display("FAIL stream_rv p=%0d got=%b exp=%b", p, rv_a, exp_rv); end
            if (exp_rv) begin
                total++; if (r_a !== vec(p - 2)) begin bad++; $display("FAIL stream_data p=%0d got=%h exp=%h", p, r_a, vec(p - 2)); end
                $display("stream: out p=%0d data=%h", p, r_a);
            end
        end
    endtask

    task automatic test_stall();
        for (int p = 0; p < 3; p++) begin
            drive_a(1'b1, vec(p + 1), 1'b0, 1'b0);
            total++; if (dr_a !== 1'b1) begin bad++; $display("FAIL fill_ready p=%0d got=%b exp=1", p, dr_a); end
        end
        for (int p = 0; p < 5; p++) begin
            drive_a(1'b1, vec(4), 1'b0, 1'b0);
            total++; if (dr_a !== 1'b0) begin bad++; $display("FAIL stall_ready s=%0d got=%b exp=0", p, dr_a); end
            total++; if (rv_a !== 1'b1) begin bad++; $display("FAIL stall_rv s=%0d got=%b exp=1", p, rv_a); end
            total++; if (r_a !== vec(1)) begin bad++; $display("FAIL stall_data s=%0d got=%h exp=%h", p, r_a, vec(1)); end
            total++; if (cnt_a !== 2'd3) begin bad++; $display("FAIL stall_cnt s=%0d got=%0d exp=3", p, cnt_a); end
        end
        for (int p = 0; p < 3; p++) begin
            drive_a(1'b0, '0, 1'b1, 1'b0);
            total++; if (rv_a !== 1'b1) begin bad++; $display("FAIL drain_rv k=%0d got=%b exp=1", p, rv_a); end
            total++; if (r_a !== vec(p + 1)) begin bad++; $display("FAIL drain_data k=%0d got=%h exp=%h", p, r_a, vec(p + 1)); end
            total++; if (cnt_a !== 2'(3 - p)) begin bad++; $display("FAIL drain_cnt k=%0d got=%0d exp=%0d", p, cnt_a, 3 - p); end
            $display("stall: drained %h", r_a);
        end
        drive_a(1'b0, '0, 1'b1, 1'b0);
        total++; if (rv_a !== 1'b0) begin bad++; $display("FAIL drain_empty_rv got=%b exp=0", rv_a); end
        total++; if (cnt_a !== 2'd0) begin bad++; $display("FAIL drain_empty_cnt got=%0d exp=0", cnt_a); end
    endtask

    task automatic test_collapse();
        logic [17:0] va, vb;
        va = 18'h2A5A5;
        vb = 18'h15A5A;
        drive_b(1'b1, va, 1'b1);
        drive_b(1'b0, '0, 1'b1);
        drive_b(1'b0, '0, 1'b1);
        drive_b(1'b1, vb, 1'b1);
        total++; if (dr_b !== 1'b1) begin bad++; $display("FAIL collapse_ready got=%b exp=1", dr_b); end
        for (int p = 0; p < 4; p++) begin
            drive_b(1'b0, '0, 1'b0);
            total++; if (rv_b !== 1'b1) begin bad++; $display("FAIL collapse_rv s=%0d got=%b exp=1", p, rv_b); end
            total++; if (r_b !== va) begin bad++; $display("FAIL collapse_hold s=%0d got=%h exp=%h", p, r_b, va); end
            total++; if (cnt_b !== 3'd2) begin bad++; $display("FAIL collapse_cnt s=%0d got=%0d exp=2", p, cnt_b); end
        end
        drive_b(1'b0, '0, 1'b1);
        total++; if (rv_b !== 1'b1 || r_b !== va) begin bad++; $display("FAIL collapse_outA rv=%b got=%h exp=%h", rv_b, r_b, va); end
        drive_b(1'b0, '0, 1'b1);
        total++; if (rv_b !== 1'b1 || r_b !== vb) begin bad++; $display("FAIL collapse_outB rv=%b got=%h exp=%h", rv_b, r_b, vb); end
        drive_b(1'b0, '0, 1'b1);
        total++; if (rv_b !== 1'b0 || cnt_b !== 3'd0) begin bad++; $display("FAIL collapse_empty rv=%b cnt=%0d exp rv=0 cnt=0", rv_b, cnt_b); end
        $display("collapse: A and B emerged back to back");
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 3; p++) drive_a(1'b1, vec(9 + p), 1'b0, 1'b0);
        for (int p = 0; p < 6; p++) begin
            drive_a(1'b1, vec(12 + p), 1'b1, 1'b0);
            total++; if (dr_a !== 1'b1) begin bad++; $display("FAIL b2b_ready k=%0d got=%b exp=1", p, dr_a); end
            total++; if (rv_a !== 1'b1 || r_a !== vec(9 + p)) begin bad++; $display("FAIL b2b_data k=%0d rv=%b got=%h exp=%h", p, rv_a, r_a, vec(9 + p)); end
            total++; if (cnt_a !== 2'd3) begin bad++; $display("FAIL b2b_cnt k=%0d got=%0d exp=3", p, cnt_a); end
        end
        for (int p = 0; p < 3; p++) begin
            drive_a(1'b0, '0, 1'b1, 1'b0);
            total++; if (rv_a !== 1'b1 || r_a !== vec(15 + p)) begin bad++; $display("FAIL b2b_drain k=%0d rv=%b got=%h exp=%h", p, rv_a, r_a, vec(15 + p)); end
        end
        drive_a(1'b0, '0, 1'b1, 1'b0);
        total++; if (cnt_a !== 2'd0) begin bad++; $display("FAIL b2b_empty_cnt got=%0d exp=0", cnt_a); end
        $display("back_to_back: 6 simultaneous transfers");
    endtask

    task automatic test_flush();
        drive_a(1'b1, vec(21), 1'b0, 1'b0);
        drive_a(1'b1, vec(22), 1'b0, 1'b0);
        drive_a(1'b1, vec(23), 1'b0, 1'b1);
        total++; if (dr_a !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", dr_a); end
        total++; if (cnt_a !== 2'd2) begin bad++; $display("FAIL flush_precnt got=%0d exp=2", cnt_a); end
        for (int p = 0; p < 5; p++) begin
            drive_a(1'b0, '0, 1'b1, 1'b0);
            total++; if (rv_a !== 1'b0) begin bad++; $display("FAIL flush_rv k=%0d got=%b exp=0", p, rv_a); end
            total++; if (cnt_a !== 2'd0) begin bad++; $display("FAIL flush_cnt k=%0d got=%0d exp=0", p, cnt_a); end
        end
        $display("flush: two vectors discarded");
    endtask

    task automatic test_midreset();
        drive_a(1'b1, vec(31), 1'b1, 1'b0);
        drive_a(1'b1, vec(32), 1'b1, 1'b0);
        drive_a(1'b1, vec(33), 1'b1, 1'b0);
        clock_sreset = 1'b1;
        drive_a(1'b0, '0, 1'b1, 1'b0);
        clock_sreset = 1'b0;
        for (int p = 0; p < 4; p++) begin
            if (p > 0) drive_a(1'b0, '0, 1'b1, 1'b0);
            total++; if (rv_a !== 1'b0) begin bad++; $display("FAIL midreset_rv k=%0d got=%b exp=0", p, rv_a); end
            total++; if (cnt_a !== 2'd0) begin bad++; $display("FAIL midreset_cnt k=%0d got=%0d exp=0", p, cnt_a); end
        end
        $display("midreset: in-flight vectors discarded");
    endtask

    task automatic test_passthru();
        logic [3:0] dv_t, rr_t, fl_t;
        logic [17:0] d_t [4];
        logic exp_rv, exp_dr;
        dv_t = 4'b1011; rr_t = 4'b1101; fl_t = 4'b1000;
        d_t = '{18'h12345, 18'h3FFFF, 18'h00001, 18'h2AAAA};
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            dv_c = dv_t[k]; rr_c = rr_t[k]; fl_c = fl_t[k]; d_c = d_t[k];
            #1;
            exp_rv = dv_t[k] && !fl_t[k];
            exp_dr = rr_t[k] && !fl_t[k];
            total++; if (r_c !== d_t[k]) begin bad++; $display("FAIL pass_data k=%0d got=%h exp=%h", k, r_c, d_t[k]); end
            total++; if (rv_c !== exp_rv) begin bad++; $display("FAIL pass_rv k=%0d got=%b exp=%b", k, rv_c, exp_rv); end
            total++; if (dr_c !== exp_dr) begin bad++; $display("FAIL pass_ready k=%0d got=%b exp=%b", k, dr_c, exp_dr); end
            total++; if (cnt_c !== 1'b0) begin bad++; $display("FAIL pass_cnt k=%0d got=%0d exp=0", k, cnt_c); end
            $display("passthru: k=%0d data=%h rv=%b rdy=%b", k, r_c, rv_c, dr_c);
        end
    endtask

    initial begin
        clock_sreset = 1'b1;
        fl_a = 1'b0; dv_a = 1'b0; rr_a = 1'b1; d_a = '0;
        fl_b = 1'b0; dv_b = 1'b0; rr_b = 1'b1; d_b = '0;
        fl_c = 1'b0; dv_c = 1'b0; rr_c = 1'b0; d_c = '0;
        repeat (2) @(negedge clock);
        test_reset();
        test_stream();
        test_stall();
        test_collapse();
        test_back_to_back();
        test_flush();
        test_midreset();
        test_passthru();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
